// File: rtl/fht_load_sched_if.sv
// fht_load_sched_if: sample stream, bank write/read ports, core handshake and result stream of the FHT load scheduler
interface fht_load_sched_if #(
  parameter int A_BIT = 8,
  parameter int D_BIT = 16
);
  logic [D_BIT-1:0] data;
  logic             valid;
  logic             ready;
  logic [3:0]       we;
  logic [A_BIT-1:0] wr_addr;
  logic [D_BIT-1:0] wr_data;
  logic             fht_start;
  logic             fht_rdy;
  logic             rd_en;
  logic [A_BIT-1:0] rd_addr;
  logic [D_BIT-1:0] rd_data_0;
  logic [D_BIT-1:0] rd_data_1;
  logic [D_BIT-1:0] rd_data_2;
  logic [D_BIT-1:0] rd_data_3;
  logic [D_BIT-1:0] out_data;
  logic             out_valid;
  logic             out_last;
  logic             busy;
  logic             err;
  modport master (
    output data, valid, fht_rdy, rd_data_0, rd_data_1, rd_data_2, rd_data_3,
    input  ready, we, wr_addr, wr_data, fht_start, rd_en, rd_addr,
           out_data, out_valid, out_last, busy, err
  );
  modport slave (
    input  data, valid, fht_rdy, rd_data_0, rd_data_1, rd_data_2, rd_data_3,
    output ready, we, wr_addr, wr_data, fht_start, rd_en, rd_addr,
           out_data, out_valid, out_last, busy, err
  );
endinterface

// File: rtl/fht_load_sched.sv
// fht_load_sched: loads a frame bit-reversed into four banks, starts the FHT core, then streams results in natural order
module fht_load_sched #(
  parameter int A_BIT = 8,
  parameter int D_BIT = 16,
  parameter int TMO   = 15
) (
  input logic              clk,
  input logic              rst,
  fht_load_sched_if.slave  bus
);
  localparam int N_BIT = A_BIT + 2;
  localparam int T_BIT = $clog2(TMO + 1);
  typedef enum logic [2:0] {LOAD, START, WAIT_BUSY, WAIT_DONE, UNLOAD, FLUSH} state_t;
  state_t           state;
  logic [N_BIT-1:0] n;
  logic [N_BIT-1:0] rev;
  logic [N_BIT-1:0] k;
  logic [T_BIT-1:0] tmo;
  logic [1:0]       sel_d;
  logic             en_d;
  logic             last_d;
  logic [D_BIT-1:0] rd_mux;
  logic             acc;
  for (genvar i = 0; i < N_BIT; i++) begin : g_rev
    assign rev[i] = n[N_BIT-1-i];
  end
  assign acc         = bus.valid && bus.ready;
  assign bus.rd_en   = state == UNLOAD;
  assign bus.rd_addr = k[N_BIT-1:2];
  assign rd_mux = sel_d == 2'd0 ? bus.rd_data_0 :
                  sel_d == 2'd1 ? bus.rd_data_1 :
                  sel_d == 2'd2 ? bus.rd_data_2 : bus.rd_data_3;
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= LOAD;
      n             <= '0;
      k             <= '0;
      tmo           <= '0;
      sel_d         <= '0;
      en_d          <= 1'b0;
      last_d        <= 1'b0;
      bus.ready     <= 1'b0;
      bus.busy      <= 1'b0;
      bus.we        <= '0;
      bus.wr_addr   <= '0;
      bus.wr_data   <= '0;
      bus.fht_start <= 1'b0;
      bus.err       <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.out_data  <= '0;
    end else begin
      bus.we        <= '0;
      bus.fht_start <= 1'b0;
      bus.err       <= 1'b0;
      // two-stage read pipeline: bank RAM latency, then output register
      en_d          <= state == UNLOAD;
      sel_d         <= k[1:0];
      last_d        <= state == UNLOAD && k == '1;
      bus.out_valid <= en_d;
      bus.out_last  <= last_d;
      bus.out_data  <= en_d ? rd_mux : '0;
      case (state)
        LOAD: begin
          bus.ready <= !(acc && n == '1);
          bus.busy  <= acc && n == '1;
          if (acc) begin
            bus.we      <= 4'b0001 << rev[1:0];
            bus.wr_addr <= rev[N_BIT-1:2];
            bus.wr_data <= bus.data;
            n           <= n + 1'b1;
            state       <= n == '1 ? START : LOAD;
          end
        end
        START: begin
          bus.fht_start <= 1'b1;
          tmo           <= '0;
          state         <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!bus.fht_rdy) state <= WAIT_DONE;
          else if (tmo == T_BIT'(TMO - 1)) begin
            bus.err   <= 1'b1;
            bus.ready <= 1'b1;
            bus.busy  <= 1'b0;
            state     <= LOAD;
          end else tmo <= tmo + 1'b1;
        end
        WAIT_DONE: begin
          if (bus.fht_rdy) begin
            k     <= '0;
            state <= UNLOAD;
          end
        end
        UNLOAD: begin
          k     <= k + 1'b1;
          state <= k == '1 ? FLUSH : UNLOAD;
        end
        FLUSH: begin
          if (bus.out_last) begin
            bus.ready <= 1'b1;
            bus.busy  <= 1'b0;
            state     <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule

// File: doc/fht_load_sched.md
FHT_LOAD_SCHED -- requirements
Module: fht_load_sched

Interface
REQ-001 Parameter A_BIT, default 8, bank address width; frame length N = 4*2^A_BIT points (1024 by default).
REQ-002 Parameter D_BIT, default 16, sample/result data width.
REQ-003 Parameter TMO, default 15, maximum cycles to wait for the FHT core to go busy after oFHT_START.
REQ-004 iCLK  in  1  single clock; all logic on rising edge.
REQ-005 iRESET  in  1  synchronous, active-high reset.
REQ-006 iDATA / iVALID / oREADY  in D_BIT / in 1 / out 1  input sample stream; a sample transfers when iVALID & oREADY.
REQ-007 oWE  out  4  one-hot bank write enable; oWR_ADDR out A_BIT; oWR_DATA out D_BIT.
REQ-008 oFHT_START  out  1  one-cycle start pulse to the FHT control core.
REQ-009 iFHT_RDY  in  1  core ready; low = conversion running.
REQ-010 oRD_EN  out  1; oRD_ADDR  out  A_BIT  result read port, identical address on all four banks.
REQ-011 iRD_DATA_0..iRD_DATA_3  in  D_BIT each  bank read data, valid 1 cycle after oRD_EN.
REQ-012 oOUT_DATA out D_BIT; oOUT_VALID out 1; oOUT_LAST out 1  result stream, natural order, no backpressure.
REQ-013 oBUSY  out  1  high in every state except LOAD; oERR  out  1  one-cycle timeout pulse.

Function
REQ-014 States LOAD, START, WAIT_BUSY, WAIT_DONE, UNLOAD, FLUSH; one state register, encoding free.
REQ-015 LOAD: oREADY=1; sample counter n (A_BIT+2 bits) counts accepted samples 0..N-1.
REQ-016 Per accepted sample: r = bit-reverse of n over A_BIT+2 bits; oWE one-hot at bit r[1:0]; oWR_ADDR = r[A_BIT+1:2]; oWR_DATA = iDATA; all registered, visible the cycle after acceptance.
REQ-017 oWE = 0 in every cycle without an accepted sample in the previous cycle.
REQ-018 Acceptance of sample n = N-1 -> n wraps to 0, state START; oREADY drops the next cycle.
REQ-019 START: oFHT_START=1 for exactly one cycle, the cycle after the last bank write is issued; next state WAIT_BUSY.
REQ-020 WAIT_BUSY: iFHT_RDY=0 -> WAIT_DONE; timeout counter reaches TMO cycles with iFHT_RDY=1 -> oERR pulse 1 cycle, state LOAD, frame discarded.
REQ-021 WAIT_DONE: iFHT_RDY=1 -> UNLOAD, read counter k cleared to 0.
REQ-022 UNLOAD: oRD_EN=1 every cycle; bank select = k[1:0]; oRD_ADDR = k[A_BIT+1:2]; k increments by 1; after k = N-1 -> FLUSH.
REQ-023 Output: bank select delayed 1 cycle alongside oRD_EN; oOUT_VALID = delayed oRD_EN; oOUT_DATA = iRD_DATA_<delayed select>, registered (output 2 cycles after oRD_EN).
REQ-024 oOUT_LAST=1 only with the output for k = N-1.
REQ-025 FLUSH: wait until oOUT_LAST has been emitted, then LOAD; exactly N oOUT_VALID cycles per frame, back-to-back.
REQ-026 iVALID outside LOAD: ignored, no write, no counter change.
REQ-027 iFHT_RDY toggles outside WAIT_BUSY/WAIT_DONE: ignored.

Reset
REQ-028 iRESET=1 at any clock edge, including mid-frame or mid-unload: state LOAD; n, k, timeout counter = 0; pipeline valid bits cleared.
REQ-029 Outputs while reset is applied and in the cycle after: oREADY=0, then 1 from the first cycle with iRESET=0; oWE=0, oWR_ADDR=0, oWR_DATA=0, oFHT_START=0, oRD_EN=0, oRD_ADDR=0, oOUT_VALID=0, oOUT_LAST=0, oOUT_DATA=0, oERR=0, oBUSY=0.
REQ-030 Partial frame at reset is discarded; no oFHT_START is issued for it.

Verification
REQ-031 A_BIT=8, stream n=0,1,2,512,1023 -> oWE/oWR_ADDR = 0001/0, 0001/128, 0001/64, 0010/0, 1000/255.
REQ-032 1024 back-to-back samples, core model drops iFHT_RDY 3 cycles after start, raises it 300 cycles later -> single oFHT_START the cycle after the 1024th write, oBUSY=1 from then until FLUSH ends.
REQ-033 Unload with bank model q = {bank,addr} -> oOUT_DATA sequence 0x000,0x100,0x200,0x300,0x001,...; 1024 valids; oOUT_LAST only on the 1024th; first valid 2 cycles after first oRD_EN.
REQ-034 Core never drops iFHT_RDY -> oERR pulses once exactly TMO=15 cycles after entering WAIT_BUSY; oREADY=1 the following cycle; no read cycles.
REQ-035 iRESET asserted after 500 samples, then a full 1024-sample frame -> first post-reset sample writes bank 0 addr 0; exactly one oFHT_START.
REQ-036 iVALID held high during WAIT_DONE and UNLOAD -> oWE stays 0; next frame's first write maps n=0.
